ntt_stage_controller: RTL

NTT_STAGE_CONTROLLER -- requirements
Module: ntt_stage_controller

---
 rtl/ntt_stage_controller.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/ntt_stage_controller.sv
// Stage sequencer for an NTT core array: walks every butterfly stage through READ/DRAIN,
// ping-pongs the RAM banks between stages and replays read addresses as write-backs L cycles later.
module ntt_stage_controller #(
    parameter int LOG_CORE_COUNT = 5,
    parameter int LOG_WORDS      = 5,
    parameter int NUM_STAGES     = 12,
    parameter int LATENCY        = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [3:0] log_m,
    output logic [9:0] i,
    output logic [8:0] read_address,
    output logic [1:0] mode,
    output logic       read_select,
    output logic       write_select,
    output logic       upper_write_enable,
    output logic       lower_write_enable,
    output logic [8:0] upper_write_address,
    output logic [8:0] lower_write_address
);

    localparam int W     = 1 << LOG_WORDS;
    localparam int MAXC  = (W > LATENCY) ? W : LATENCY;
    localparam int CNT_W = $clog2(MAXC + 1);
    localparam logic [CNT_W-1:0] LAST_READ  = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(LATENCY - 1);
    localparam logic [3:0]       LAST_STAGE = 4'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        NEXT,
        DONE
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [3:0]         stage, stage_next;
    logic [LATENCY-1:0] pipe_valid;
    logic [8:0]         pipe_addr [LATENCY];
    logic [1:0]         stage_mode;
    logic [3:0]         shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            stage <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            stage <= stage_next;
        end
    end

    // Early stages address twiddles per core, the last stage has its own mode, the rest use the group index.
    assign stage_mode = (32'(stage) < LOG_CORE_COUNT) ? 2'd0 :
                        (stage == LAST_STAGE)         ? 2'd2 : 2'd1;
    assign shift      = LAST_STAGE - stage;

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        stage_next   = stage;
        busy         = (state != IDLE);
        done         = (state == DONE);
        log_m        = '0;
        read_address = '0;
        mode         = '0;
        i            = '0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                    cnt_next   = '0;
                    stage_next = '0;
                end
            end
            READ: begin
                if (cnt == LAST_READ) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == LAST_DRAIN) begin
                    cnt_next   = '0;
                    state_next = (stage == LAST_STAGE) ? DONE : NEXT;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            NEXT: begin
                stage_next = stage + 4'd1;
                state_next = READ;
            end
            DONE: begin
                stage_next = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (state == READ || state == DRAIN || state == NEXT) log_m = stage;
        if (state == READ) read_address = 9'(cnt);
        if (state == READ || state == DRAIN) mode = stage_mode;
        if (mode == 2'd1) i = 10'(read_address) >> shift;
    end

    // Write-back delay line; the final stage write lands in its last DRAIN cycle, before the bank toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            for (int k = 0; k < LATENCY; k++) pipe_addr[k] <= '0;
        end else begin
            pipe_valid[0] <= (state == READ);
            pipe_addr[0]  <= read_address;
            for (int k = 1; k < LATENCY; k++) begin
                pipe_valid[k] <= pipe_valid[k-1];
                pipe_addr[k]  <= pipe_addr[k-1];
            end
        end
    end

    assign read_select         = stage[0];
    assign write_select        = ~stage[0];
    assign upper_write_enable  = pipe_valid[LATENCY-1];
    assign lower_write_enable  = pipe_valid[LATENCY-1];
    assign upper_write_address = pipe_valid[LATENCY-1] ? pipe_addr[LATENCY-1] : 9'd0;
    assign lower_write_address = pipe_valid[LATENCY-1] ? pipe_addr[LATENCY-1] : 9'd0;

endmodule
